// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the digit-serial BCD adder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bcd_pkg;

    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder cell: a_d + b_d + ci with +6 correction above 9.
// Latency: purely combinational.
// Backpressure: not applicable.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic               ci,
    output logic [DIGIT_W-1:0] digit,
    output logic               co
);

    logic [DIGIT_W:0] raw;
    logic [DIGIT_W:0] corr;

    assign raw  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, ci};
    assign corr = raw + (DIGIT_W+1)'(BCD_CORR);

    // Digits above 9 (including non-BCD inputs) wrap through the +6 correction.
    always_comb begin
        digit = raw[DIGIT_W-1:0];
        co    = 1'b0;
        if (raw > (DIGIT_W+1)'(BCD_MAX)) begin
            digit = corr[DIGIT_W-1:0];
            co    = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial N-digit BCD adder, one digit per clock LSD first; BCD_INPUT_CHECK_EN adds a sticky non-BCD flag.
// Latency: out_valid rises DIGITS clocks after the input accept edge.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DIGITS*4-1:0]     a,
    input  logic [DIGITS*4-1:0]     b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGITS*4-1:0]     sum,
    output logic                    cout,
    output logic                    err
);

    localparam int W    = DIGITS * DIGIT_W;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t            state;
    logic [W-1:0]      a_sh;
    logic [W-1:0]      b_sh;
    logic [W-1:0]      res;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [DIGIT_W-1:0] dig;
    logic               co;
    logic [W+DIGIT_W-1:0] res_cat;
    logic [W-1:0]       res_nxt;
    logic               last;

    bcd_digit_add u_digit (
        .a_d   (a_sh[DIGIT_W-1:0]),
        .b_d   (b_sh[DIGIT_W-1:0]),
        .ci    (carry),
        .digit (dig),
        .co    (co)
    );

    // New digit enters at the top so the LSD ends up at bit 0 after DIGITS shifts.
    assign res_cat = {dig, res};
    assign res_nxt = res_cat[W+DIGIT_W-1:DIGIT_W];
    assign last    = (idx == IDXW'(DIGITS - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Control FSM plus operand/result shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        idx   <= '0;
                        res   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    res   <= res_nxt;
                    carry <= co;
                    idx   <= idx + IDXW'(1);
                    if (last) begin
                        sum   <= res_nxt;
                        cout  <= co;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_q;

    // Sticky flag for any processed operand digit above 9; cleared on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            err_q <= 1'b0;
        end else if (state == ADD) begin
            if (a_sh[DIGIT_W-1:0] > DIGIT_W'(BCD_MAX) ||
                b_sh[DIGIT_W-1:0] > DIGIT_W'(BCD_MAX)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a decimal reference model.
// Latency: checks out_valid arrives exactly DIGITS edges after accept.
// Backpressure: exercises out_ready stalls and blocked input accepts during DONE.
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain decimal arithmetic for legal BCD operands; the
    // digit-wise correction rule only for operands containing non-BCD digits.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mci,
                                  output logic [W-1:0] ms, output logic mco, output logic me);
        bit          legal;
        longint      va;
        longint      vb;
        longint      tot;
        longint      p;
        int          raw;
        int          c;
        legal = 1'b1;
        me    = 1'b0;
        ms    = '0;
        mco   = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) begin
                legal = 1'b0;
                me    = 1'b1;
            end
        end
        if (legal) begin
            va = 0;
            vb = 0;
            p  = 1;
            for (int i = D - 1; i >= 0; i--) begin
                va = va * 10 + longint'(ma[4*i +: 4]);
                vb = vb * 10 + longint'(mb[4*i +: 4]);
                p  = p * 10;
            end
            tot = va + vb + longint'(mci);
            mco = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < D; i++) begin
                ms[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            c = int'(mci);
            for (int i = 0; i < D; i++) begin
                raw = int'(ma[4*i +: 4]) + int'(mb[4*i +: 4]) + c;
                if (raw > 9) begin
                    ms[4*i +: 4] = 4'((raw + 6) % 16);
                    c = 1;
                end else begin
                    ms[4*i +: 4] = 4'(raw);
                    c = 0;
                end
            end
            mco = c[0];
        end
`ifndef BCD_INPUT_CHECK_EN
        me = 1'b0;
`endif
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    function automatic logic [W-1:0] rand_any();
        logic [W-1:0] v;
        for (int i = 0; i < D; i++) v[4*i +: 4] = 4'($urandom_range(0, 15));
        return v;
    endfunction

    // One full transaction; all sampling happens 1 time unit after a rising edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tci,
                          input int hold, input string tag);
        logic [W-1:0] es;
        logic         ec;
        logic         ee;
        int           n;
        int           lat;
        model(ta, tb_, tci, es, ec, ee);
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_ready_before"}, 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        a         = ta;
        b         = tb_;
        cin       = tci;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = rand_any();
        b        = rand_any();
        cin      = 1'($urandom_range(0, 1));
        chk({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 50);
        chk({tag, "_latency"}, 64'(lat), 64'(D));
        chk({tag, "_sum"},  64'(sum),  64'(es));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_err"},  64'(err),  64'(ee));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = rand_bcd();
            b        = rand_bcd();
            @(posedge clk); #1;
            chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_stall_ready"}, 64'(in_ready),  64'd0);
            chk({tag, "_stall_sum"},   64'({cout, err, sum}), 64'({ec, ee, es}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_idle_ready"}, 64'(in_ready),  64'd1);
        chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_sum_held"},   64'({cout, sum}), 64'({ec, es}));
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_err",       64'(err),       64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h5678, 1'b0, 0, "basic");
        chk("basic_abs_sum", 64'(sum), 64'h6912);
        run_op(16'h9999, 16'h0001, 1'b0, 0, "ripple");
        chk("ripple_abs", 64'({cout, sum}), 64'h10000);
        run_op(16'h4999, 16'h5000, 1'b1, 0, "cin_ripple");
        chk("cin_ripple_abs", 64'({cout, sum}), 64'h10000);
        run_op(16'h0000, 16'h0000, 1'b0, 0, "no_stale");
        chk("no_stale_abs", 64'({cout, sum}), 64'h0);
        run_op(16'h2718, 16'h3141, 1'b0, 5, "backpressure");
        run_op(16'h000C, 16'h0001, 1'b1, 0, "nonbcd");
        chk("nonbcd_abs", 64'({cout, sum}), 64'h0014);
        run_op(16'h0011, 16'h0022, 1'b0, 0, "err_clear");
        chk("err_clear_abs", 64'(err), 64'd0);

        // Abort mid-ADD: reset sampled on the second ADD cycle's closing edge.
        a        = 16'h1234;
        b        = 16'h5678;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_sum",       64'(sum),       64'd0);
        chk("abort_cout",      64'(cout),      64'd0);
        chk("abort_err",       64'(err),       64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort_no_result", 64'(seen), 64'd0);

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 3) == 0)
                run_op(rand_any(), rand_any(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), "rand_any");
            else
                run_op(rand_bcd(), rand_bcd(), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3), "rand_bcd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Digit-serial multi-digit BCD adder: accepts two DIGITS-wide packed BCD operands plus carry-in over a valid/ready handshake.
- Adds one 4-bit digit per clock, least-significant digit first, through a single combinational digit cell.
- Returns the packed BCD sum and decimal carry-out over a second valid/ready handshake.
- Sits upstream of the single-digit BCD adder datapath usage and extends it to N-digit operands for the counter/display blocks.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set.
- a  input  4*DIGITS  packed BCD operand A; digit i at bits [4i+3:4i].
- b  input  4*DIGITS  packed BCD operand B.
- cin  input  1  decimal carry-in to digit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  4*DIGITS  packed BCD result.
- cout  output  1  decimal carry-out of the most-significant digit.
- err  output  1  at least one operand digit was >9; only meaningful with the optional feature.

Behaviour:
- One clock clk; synchronous, active-high reset rst.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, err=0; internal operand, carry and digit-index registers are cleared.
- FSM states IDLE, ADD, DONE:
  - IDLE: in_ready=1. On in_valid & in_ready, latch a, b and cin into internal shift registers, clear the digit index and err, then go to ADD.
  - ADD: in_ready=0, out_valid=0. Each cycle processes digit idx.
    - raw = a_d + b_d + carry, 5 bits.
    - If raw > 9: digit = (raw + 6)[3:0], carry = 1. Otherwise digit = raw[3:0], carry = 0.
    - The digit shifts into the result register from the top, so LSD-first order ends correctly aligned.
    - After the cycle with idx = DIGITS-1, load sum and cout into the output registers and go to DONE.
  - DONE: out_valid=1. sum, cout and err stay stable while out_ready=0. On out_ready, go to IDLE.
- Handshake rules:
  - in_ready is high only in IDLE.
  - A result accept and a new input accept never happen in the same cycle. Minimum initiation interval is DIGITS+2 cycles.
- Latency: out_valid rises on the DIGITS-th rising edge after the accepting edge.
- sum and cout hold the last completed result after DONE exits. They update only on entry to DONE.
- Non-BCD digits (>9) are not rejected. They follow the same correction rule, which gives deterministic results, e.g. 12+1+1 gives digit 4, carry 1.
- Input changes while busy are ignored, because operands are latched in IDLE.
- Reset asserted in any state, including mid-ADD: the next state is IDLE with all reset values. The partial result is discarded and no out_valid is produced.

Optional Feature:
- Macro BCD_INPUT_CHECK_EN.
- Defined: in ADD, err is set sticky if a_d > 9 or b_d > 9 for any processed digit. err is cleared on accept and on reset, and is valid alongside out_valid.
- Undefined: err is tied to 0 and the comparison logic is not synthesised.
- sum and cout are identical in both builds.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=9, BCD_CORR=6.
  - State enum type with IDLE, ADD, DONE.
- Sub-module bcd_digit_add: combinational a_d, b_d, ci -> digit, co, using the correction rule above. It is instantiated once in bcd_serial_adder.

Test Plan (DIGITS=4):
- a=0x1234, b=0x5678, cin=0, out_ready=1 -> sum=0x6912, cout=0, out_valid exactly 4 edges after accept, in_ready returns high after the result is taken.
- a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all digits).
- a=0x4999, b=0x5000, cin=1 -> sum=0x0000, cout=1; then a=0x0000, b=0x0000, cin=0 -> sum=0x0000, cout=0 (no stale carry).
- Backpressure: result ready, out_ready held 0 for 5 cycles -> out_valid stays 1, sum/cout unchanged, in_ready=0, a new in_valid is not accepted; out_ready=1 -> IDLE next cycle.
- a=0x000C, b=0x0001, cin=1 -> sum=0x0014, cout=0. err=1 with BCD_INPUT_CHECK_EN defined, err=0 without; a following valid op clears err.
- Accept a=0x1234, b=0x5678, assert rst during the 2nd ADD cycle -> next cycle in_ready=1, out_valid=0, sum=0, cout=0, err=0; no out_valid ever appears for the aborted op.
